// File: rtl/counter_4b_pkg.sv
// Shared mode codes and controller state encoding for the 4-bit counter initiator.
package counter_4b_pkg;

  localparam logic [1:0] COUNT_UP     = 2'b00;
  localparam logic [1:0] COUNT_DOWN   = 2'b01;
  localparam logic [1:0] COUNT_3_DOWN = 2'b10;
  localparam logic [1:0] CHARGE       = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOADP = 2'b01,
    RUN   = 2'b10,
    FIN   = 2'b11
  } state_e;

endpackage

// File: rtl/counter_4b_ctrl_if.sv
// Job command channel (valid/ready) between the sequencer and the counter initiator.
interface counter_4b_ctrl_if #(
  parameter int CNT_W = 4,
  parameter int LEN_W = 8
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_MODO;
  logic [CNT_W-1:0] CMD_D;
  logic [LEN_W-1:0] CMD_LEN;

  modport master (output CMD_VALID, CMD_MODO, CMD_D, CMD_LEN, input CMD_READY);
  modport slave  (input CMD_VALID, CMD_MODO, CMD_D, CMD_LEN, output CMD_READY);
endinterface

// File: rtl/counter_4b_model.sv
// One-step behavioural model of the counter: next value and wrap flag for a given mode.
module counter_4b_model
  import counter_4b_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0] shadow_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] d_i,
  output logic [CNT_W-1:0] next_q_o,
  output logic             wrap_o
);

  always_comb begin
    next_q_o = shadow_i;
    wrap_o   = 1'b0;
    case (mode_i)
      COUNT_UP: begin
        next_q_o = shadow_i + CNT_W'(1);
        wrap_o   = (shadow_i == {CNT_W{1'b1}});
      end
      COUNT_DOWN: begin
        next_q_o = shadow_i - CNT_W'(1);
        wrap_o   = (shadow_i == '0);
      end
      COUNT_3_DOWN: begin
        // a step of 3 from 0, 1 or 2 crosses below zero
        next_q_o = shadow_i - CNT_W'(3);
        wrap_o   = (shadow_i <= CNT_W'(2));
      end
      default: begin
        next_q_o = d_i;
        wrap_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/counter_4b_ctrl.sv
// Runs one preload+count job on a counter_4b, shadows its Q, checks Q/LOAD every
// cycle and reports DONE, the wrap count and a per-job error flag.
module counter_4b_ctrl
  import counter_4b_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             RESET_N,
  counter_4b_ctrl_if.slave cmd,
  output logic             ENABLE,
  output logic [1:0]       MODO,
  output logic [CNT_W-1:0] D,
  input  logic [CNT_W-1:0] Q,
  input  logic             LOAD,
  output logic             DONE,
  output logic [LEN_W-1:0] WRAPS,
  output logic             ERR
);

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [1:0]       modo_q;
  logic [CNT_W-1:0] d_q;
  logic [CNT_W-1:0] shadow_q;
  logic [CNT_W-1:0] shadow_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] wraps_q;
  logic             enable_q;
  logic             done_q;
  logic             err_q;
  logic             first_q;
  logic             wrap_d;
  logic             check_fail;

  counter_4b_model #(.CNT_W(CNT_W)) u_model (
    .shadow_i (shadow_q),
    .mode_i   (mode_q),
    .d_i      (d_q),
    .next_q_o (shadow_d),
    .wrap_o   (wrap_d)
  );

  // first_q marks the cycle right after the preload, where LOAD must still be high
  assign check_fail    = (Q != shadow_q) || (LOAD != first_q);
  assign cmd.CMD_READY = (state_q == IDLE);

  assign ENABLE = enable_q;
  assign MODO   = modo_q;
  assign D      = d_q;
  assign DONE   = done_q;
  assign WRAPS  = wraps_q;
  assign ERR    = err_q;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      mode_q   <= COUNT_UP;
      modo_q   <= COUNT_UP;
      d_q      <= '0;
      shadow_q <= '0;
      len_q    <= '0;
      wraps_q  <= '0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd.CMD_VALID) begin
            mode_q   <= cmd.CMD_MODO;
            d_q      <= cmd.CMD_D;
            shadow_q <= cmd.CMD_D;
            len_q    <= cmd.CMD_LEN;
            wraps_q  <= '0;
            err_q    <= 1'b0;
            enable_q <= 1'b1;
            modo_q   <= CHARGE;
            first_q  <= 1'b1;
            state_q  <= LOADP;
          end
        end
        LOADP: begin
          modo_q <= mode_q;
          if (len_q != '0) begin
            enable_q <= 1'b1;
            state_q  <= RUN;
          end else begin
            enable_q <= 1'b0;
            state_q  <= FIN;
          end
        end
        RUN: begin
          if (check_fail) err_q <= 1'b1;
          if (wrap_d && (wraps_q != {LEN_W{1'b1}})) wraps_q <= wraps_q + LEN_W'(1);
          first_q  <= 1'b0;
          shadow_q <= shadow_d;
          len_q    <= len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) begin
            enable_q <= 1'b0;
            state_q  <= FIN;
          end
        end
        FIN: begin
          if (check_fail) err_q <= 1'b1;
          first_q <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
